// File: rtl/pixel_ctrl_if.sv
// Pixel controller bus: frame request in, pixel array control and data-bus drive out.
// master = frame sequencer, slave = host / pixel array side.
interface pixel_ctrl_if #(
    parameter int ROWS      = 2,
    parameter int CONV_BITS = 8
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                 start;
    logic [15:0]          expose_len;
    logic                 busy;
    logic                 erase;
    logic                 expose;
    logic                 ramp_en;
    logic [CONV_BITS-1:0] cnt_data;
    logic                 cnt_oe;
    logic [ROWS-1:0]      read;
    logic [RW-1:0]        row_idx;
    logic                 row_valid;
    logic                 frame_done;

    modport master (
        input  start, expose_len,
        output busy, erase, expose, ramp_en,
        output cnt_data, cnt_oe, read, row_idx,
        output row_valid, frame_done
    );

    modport slave (
        output start, expose_len,
        input  busy, erase, expose, ramp_en,
        input  cnt_data, cnt_oe, read, row_idx,
        input  row_valid, frame_done
    );
endinterface

// File: rtl/pixel_ctrl_fsm.sv
// Pixel frame sequencer: erase -> expose -> ramp convert -> row read -> done.
// Define PIXEL_CTRL_CONTINUOUS_EN for free-running back-to-back frames.
module pixel_ctrl_fsm #(
    parameter int ROWS         = 2,
    parameter int ERASE_CYCLES = 4,
    parameter int CONV_BITS    = 8,
    parameter int READ_CYCLES  = 3
) (
    input logic          clk,
    input logic          reset,
    pixel_ctrl_if.master bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        CONVERT,
        READ,
        DONE
    } state_t;

    state_t               state;
    logic [31:0]          cnt;
    logic [15:0]          len;
    logic                 busy;
    logic                 erase;
    logic                 expose;
    logic                 ramp_en;
    logic [CONV_BITS-1:0] cnt_data;
    logic                 cnt_oe;
    logic [ROWS-1:0]      read;
    logic [RW-1:0]        row_idx;
    logic                 row_valid;
    logic                 frame_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            len        <= 16'd1;
            busy       <= 1'b0;
            erase      <= 1'b0;
            expose     <= 1'b0;
            ramp_en    <= 1'b0;
            cnt_data   <= '0;
            cnt_oe     <= 1'b0;
            read       <= '0;
            row_idx    <= '0;
            row_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= ERASE;
                        busy  <= 1'b1;
                        erase <= 1'b1;
                        cnt   <= '0;
                        // zero-length exposure still gets one cycle
                        len   <= (bus.expose_len == 16'd0) ?
                                 16'd1 : bus.expose_len;
                    end
                end
                ERASE: begin
                    if (cnt == 32'(ERASE_CYCLES - 1)) begin
                        state  <= EXPOSE;
                        erase  <= 1'b0;
                        expose <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                EXPOSE: begin
                    if (cnt == {16'd0, len} - 32'd1) begin
                        state    <= CONVERT;
                        expose   <= 1'b0;
                        ramp_en  <= 1'b1;
                        cnt_oe   <= 1'b1;
                        cnt_data <= '0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                CONVERT: begin
                    // the ramp code itself times the phase
                    if (&cnt_data) begin
                        state     <= READ;
                        ramp_en   <= 1'b0;
                        cnt_oe    <= 1'b0;
                        cnt_data  <= '0;
                        read      <= ROWS'(1);
                        row_idx   <= '0;
                        row_valid <= (READ_CYCLES == 1);
                        cnt       <= '0;
                    end else begin
                        cnt_data <= cnt_data + 1'b1;
                    end
                end
                READ: begin
                    if (cnt == 32'(READ_CYCLES - 1)) begin
                        cnt <= '0;
                        if (row_idx == RW'(ROWS - 1)) begin
                            state      <= DONE;
                            read       <= '0;
                            row_idx    <= '0;
                            row_valid  <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            read      <= read << 1;
                            row_idx   <= row_idx + 1'b1;
                            row_valid <= (READ_CYCLES == 1);
                        end
                    end else begin
                        cnt       <= cnt + 32'd1;
                        row_valid <= (cnt + 32'd1 ==
                                      32'(READ_CYCLES - 1));
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
`ifdef PIXEL_CTRL_CONTINUOUS_EN
                    state <= ERASE;
                    erase <= 1'b1;
                    cnt   <= '0;
                    len   <= (bus.expose_len == 16'd0) ?
                             16'd1 : bus.expose_len;
`else
                    state <= IDLE;
                    busy  <= 1'b0;
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy;
    assign bus.erase      = erase;
    assign bus.expose     = expose;
    assign bus.ramp_en    = ramp_en;
    assign bus.cnt_data   = cnt_data;
    assign bus.cnt_oe     = cnt_oe;
    assign bus.read       = read;
    assign bus.row_idx    = row_idx;
    assign bus.row_valid  = row_valid;
    assign bus.frame_done = frame_done;
endmodule

// File: doc/pixel_ctrl_fsm.md
PIXEL_CTRL_FSM -- requirements
Module: pixel_ctrl_fsm

Interface
- REQ-001 The module SHALL have one clock and a synchronous, active-high reset: port clk input 1 (rising-edge clock), then port reset input 1 (synchronous, active-high).
- REQ-002 Parameter ROWS, default 2: number of pixel rows driven.
- REQ-003 Parameter ERASE_CYCLES, default 4: erase phase length in clk cycles.
- REQ-004 Parameter CONV_BITS, default 8: ramp code width; the convert phase SHALL last 2**CONV_BITS cycles.
- REQ-005 Parameter READ_CYCLES, default 3: cycles each row's read line is held.
- REQ-006 Port start, input, 1: request one frame.
- REQ-007 Port expose_len, input, 16: exposure length in cycles, sampled at frame start.
- REQ-008 Port busy, output, 1: frame in progress.
- REQ-009 Port erase, output, 1: pixel erase.
- REQ-010 Port expose, output, 1: pixel expose.
- REQ-011 Port ramp_en, output, 1: analog ramp enable.
- REQ-012 Port cnt_data, output, CONV_BITS: ramp code driven toward the pixel data bus.
- REQ-013 Port cnt_oe, output, 1: data-bus drive enable for cnt_data.
- REQ-014 Port read, output, ROWS: one-hot row read select.
- REQ-015 Port row_idx, output, $clog2(ROWS) (minimum width 1): index of the row being read.
- REQ-016 Port row_valid, output, 1: pixel data bus valid for row_idx.
- REQ-017 Port frame_done, output, 1: one-cycle end-of-frame pulse.

Function
- REQ-018 The FSM states SHALL be IDLE, ERASE, EXPOSE, CONVERT, READ and DONE; all outputs SHALL be registered.
- REQ-019 In IDLE with start=1 at edge N, the FSM SHALL enter ERASE at edge N (erase=1 from cycle N+1), latch expose_len, and set busy=1.
- REQ-020 ERASE SHALL hold erase=1 for exactly ERASE_CYCLES cycles, then go to EXPOSE.
- REQ-021 EXPOSE SHALL hold expose=1 for the latched expose_len cycles, with expose_len=0 treated as 1, then go to CONVERT.
- REQ-022 CONVERT SHALL hold ramp_en=1 and cnt_oe=1 for 2**CONV_BITS cycles, with cnt_data counting 0,1,...,max (one step per cycle), then go to READ.
- REQ-023 Outside CONVERT, cnt_data SHALL be 0 and cnt_oe SHALL be 0.
- REQ-024 READ SHALL assert read[r] for rows r=0..ROWS-1 in ascending order, READ_CYCLES cycles each, with no gap between rows; exactly one read bit SHALL be high at a time.
- REQ-025 row_idx SHALL equal r throughout row r's read window; row_valid SHALL be 1 only in the last cycle of each row's read window.
- REQ-026 erase, expose, ramp_en and read SHALL never overlap, and each phase SHALL start in the cycle immediately after the previous phase ends.
- REQ-027 After the last row, the FSM SHALL spend one cycle in DONE with frame_done=1 and busy=1, then return to IDLE with busy=0.
- REQ-028 start SHALL be ignored while busy=1, and expose_len changes SHALL have no effect while busy=1.
- REQ-029 Counters SHALL wrap cleanly, with no off-by-one at 2**CONV_BITS-1, so that the CONVERT length is exact.

Reset
- REQ-030 reset=1 at any edge SHALL force IDLE, with busy, erase, expose, ramp_en, cnt_oe, read, row_valid, frame_done, cnt_data and row_idx all 0 in the following cycle.
- REQ-031 Reset mid-frame SHALL abort the frame without asserting frame_done; reset SHALL take priority over start.

Configuration
- REQ-032 With macro PIXEL_CTRL_CONTINUOUS_EN defined, DONE SHALL go directly to ERASE, re-sampling expose_len, with busy held at 1 and frame_done still pulsed; frames SHALL repeat until reset.
- REQ-033 Without PIXEL_CTRL_CONTINUOUS_EN, DONE SHALL go to IDLE and each frame SHALL require its own start.

Verification
- REQ-034 Defaults, start pulse at edge 0, expose_len=10: erase high in cycles 1-4, expose in 5-14, ramp_en in 15-270, read[0] in 271-273, read[1] in 274-276, frame_done=1 in cycle 277, busy=0 from cycle 278.
- REQ-035 During CONVERT: cnt_data=0 in cycle 15 and 255 in cycle 270, cnt_oe=1 throughout, cnt_data=0 in cycle 271.
- REQ-036 expose_len=0: expose high for exactly 1 cycle.
- REQ-037 expose_len changed to 50 mid-frame, plus a second start while busy: frame timing unchanged, no second frame.
- REQ-038 reset asserted during CONVERT: all outputs 0 the next cycle, no frame_done; a subsequent start runs a full, correct frame.
- REQ-039 With PIXEL_CTRL_CONTINUOUS_EN: erase rises in the cycle after frame_done, and busy never drops between frames.
